// File: rtl/ymc_ctrl.sv
// Multi-cycle control sequencer for the RV32 teaching datapath. It owns the PC and steps
// FETCH/DECODE/EXEC/MEM/WB. The optional retire counter is enabled with YMC_RETIRE_CNT_EN.
module ymc_ctrl #(
  parameter int unsigned     XLEN  = 32,
  parameter logic [XLEN-1:0] ENTRY = 'h28,
  parameter int unsigned     CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  pc,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic [2:0]       state,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu   = 3'd0,
    ClsLoad  = 3'd1,
    ClsStore = 3'd2,
    ClsBeq   = 3'd3,
    ClsJal   = 3'd4
  } cls_e;

  localparam logic [6:0] OpcLoad  = 7'h03;
  localparam logic [6:0] OpcImm   = 7'h13;
  localparam logic [6:0] OpcStore = 7'h23;
  localparam logic [6:0] OpcReg   = 7'h33;
  localparam logic [6:0] OpcBeq   = 7'h63;
  localparam logic [6:0] OpcJal   = 7'h6F;
  localparam logic [6:0] OpcSys   = 7'h73;

  state_e          state_q, state_d;
  cls_e            cls_q, cls_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [2:0]      op_q, op_d;
  logic            alusrc_q, alusrc_d;
  logic            m2r_q, m2r_d;
  logic            regwrite_q, regwrite_d;
  logic            memread_q, memread_d;
  logic            memwrite_q, memwrite_d;
  logic            busy_q, busy_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            dec_legal;
  logic            dec_ecall;
  cls_e            dec_cls;
  logic [2:0]      dec_op;
  logic            dec_src;
  logic            dec_m2r;
  logic            taken;
  logic [XLEN-1:0] exec_tgt;
  logic            insn_done;

  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];

  always_comb begin
    dec_legal = 1'b1;
    dec_ecall = 1'b0;
    dec_cls   = ClsAlu;
    dec_op    = 3'b010;
    dec_src   = 1'b1;
    dec_m2r   = 1'b0;
    case (opcode)
      OpcReg: begin
        dec_src = 1'b0;
        case (funct3)
          3'b000:  dec_op = ins[30] ? 3'b110 : 3'b010;
          3'b111:  dec_op = 3'b000;
          3'b110:  dec_op = 3'b001;
          3'b010:  dec_op = 3'b111;
          default: dec_legal = 1'b0;
        endcase
      end
      OpcImm: dec_cls = ClsAlu;
      OpcLoad: begin
        dec_cls = ClsLoad;
        dec_m2r = 1'b1;
      end
      OpcStore: dec_cls = ClsStore;
      OpcBeq: begin
        dec_cls = ClsBeq;
        dec_src = 1'b0;
        dec_op  = 3'b110;
      end
      OpcJal: begin
        dec_cls = ClsJal;
        dec_src = 1'b0;
      end
      OpcSys:  dec_ecall = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  // imm is only guaranteed through EXEC, so the jal target is captured there for WB.
  assign taken    = (cls_q == ClsJal) || ((cls_q == ClsBeq) && zero);
  assign exec_tgt = taken ? (pc_q + imm) : (pc_q + XLEN'(4));

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    tgt_d     = tgt_q;
    op_d      = op_q;
    alusrc_d  = alusrc_q;
    m2r_d     = m2r_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: state_d = StDecode;
      StDecode: begin
        if (dec_ecall || !dec_legal) begin
          state_d   = StHalt;
          illegal_d = illegal_q | ~dec_legal;
        end else begin
          state_d  = StExec;
          cls_d    = dec_cls;
          op_d     = dec_op;
          alusrc_d = dec_src;
          m2r_d    = dec_m2r;
        end
      end
      StExec: begin
        tgt_d = exec_tgt;
        case (cls_q)
          ClsLoad, ClsStore: state_d = StMem;
          ClsBeq:            state_d = StFetch;
          default:           state_d = StWb;
        endcase
      end
      StMem:   state_d = (cls_q == ClsLoad) ? StWb : StFetch;
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase

    // Decoded controls are dropped as the next instruction is fetched.
    if (insn_done) begin
      op_d     = 3'b000;
      alusrc_d = 1'b0;
      m2r_d    = 1'b0;
    end
  end

  assign insn_done = (state_d == StFetch) &&
                     ((state_q == StExec) || (state_q == StMem) || (state_q == StWb));

  always_comb begin
    pc_d = pc_q;
    if (insn_done) pc_d = (state_q == StExec) ? exec_tgt : tgt_q;
  end

  assign regwrite_d = (state_d == StWb);
  assign memread_d  = (state_d == StMem) && (cls_d == ClsLoad);
  assign memwrite_d = (state_d == StMem) && (cls_d == ClsStore);
  assign busy_d     = (state_d != StIdle) && (state_d != StHalt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cls_q      <= ClsAlu;
      pc_q       <= ENTRY;
      tgt_q      <= ENTRY;
      op_q       <= 3'b000;
      alusrc_q   <= 1'b0;
      m2r_q      <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      busy_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      op_q       <= op_d;
      alusrc_q   <= alusrc_d;
      m2r_q      <= m2r_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      busy_q     <= busy_d;
      illegal_q  <= illegal_d;
    end
  end

`ifdef YMC_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  assign retired_d = insn_done ? (retired_q + CNT_W'(1)) : retired_q;

  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

  assign state    = state_q;
  assign pc       = pc_q;
  assign op       = op_q;
  assign ALUSrc   = alusrc_q;
  assign Mem2Reg  = m2r_q;
  assign RegWrite = regwrite_q;
  assign MemRead  = memread_q;
  assign MemWrite = memwrite_q;
  assign busy     = busy_q;
  assign illegal  = illegal_q;

endmodule
